// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// Module : ram_arb_pkg
// Brief  : Shared types and constants for the two-client RAM arbiter.
//          FSM state encoding (ST_IDLE, ST_WAIT) and the request-kind bit
//          (KIND_READ, KIND_WRITE) latched in each request slot.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arbState_t;

    localparam logic KIND_READ  = 1'b0;
    localparam logic KIND_WRITE = 1'b1;

endpackage : ram_arb_pkg

`default_nettype wire

// File: rtl/ram_arb_slot.sv
// ---------------------------------------------------------------------------
// Module : ram_arb_slot
// Brief  : One client's request holding slot. Latches address, write data and
//          kind from a one-cycle request pulse and keeps them until cleared.
// Ports  : clk, reset          clock, synchronous active-high reset
//          readReq, writeReq   client request pulses (write wins if both)
//          reqAddress, reqData client address / write data
//          clear               drop the held request (transaction complete)
//          pending             slot holds a request
//          address, data, kind held request contents
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arb_slot
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              readReq,
    input  logic              writeReq,
    input  logic [ADDR_W-1:0] reqAddress,
    input  logic [DATA_W-1:0] reqData,
    input  logic              clear,
    output logic              pending,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              kind
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            address <= '0;
            data    <= '0;
            kind    <= KIND_READ;
        end else if (clear) begin
            pending <= 1'b0;
        end else if (!pending && (readReq || writeReq)) begin
            // A request arriving while the slot is full is dropped: clients
            // never issue a second request before their ack.
            pending <= 1'b1;
            address <= reqAddress;
            data    <= reqData;
            kind    <= writeReq ? KIND_WRITE : KIND_READ;
        end
    end

endmodule : ram_arb_slot

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// Module : ram_arbiter
// Brief  : Two-client round-robin arbiter for a single RAM req/ack port.
//          Captures client request pulses, replays one at a time to the RAM,
//          routes the ack / read data back to the owner, and force-completes
//          a transaction whose ack never arrives (watchdog).
// Ports  : clk, reset                         clock, sync active-high reset
//          cN_ramAddress/cN_ramOut            client N address / write data
//          cN_readReq/cN_writeReq             client N request pulses
//          cN_ramIn/cN_readAck/cN_writeAck    client N read data / ack pulses
//          ramAddress/ramOut/readReq/writeReq RAM request side
//          ramIn/readAck/writeAck             RAM response side
//          busy                               transaction pending or in flight
//          timeout                            watchdog-forced completion pulse
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int              ADDR_W         = 32,
    parameter int              DATA_W         = 32,
    parameter int              TIMEOUT_CYCLES = 255,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hdeadbeef
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] c0_ramAddress,
    input  logic [DATA_W-1:0] c0_ramOut,
    input  logic              c0_readReq,
    input  logic              c0_writeReq,
    output logic [DATA_W-1:0] c0_ramIn,
    output logic              c0_readAck,
    output logic              c0_writeAck,
    input  logic [ADDR_W-1:0] c1_ramAddress,
    input  logic [DATA_W-1:0] c1_ramOut,
    input  logic              c1_readReq,
    input  logic              c1_writeReq,
    output logic [DATA_W-1:0] c1_ramIn,
    output logic              c1_readAck,
    output logic              c1_writeAck,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [DATA_W-1:0] ramOut,
    output logic              readReq,
    output logic              writeReq,
    input  logic [DATA_W-1:0] ramIn,
    input  logic              readAck,
    input  logic              writeAck,
    output logic              busy,
    output logic              timeout
);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit c_wdogEn = (TIMEOUT_CYCLES != 0);
    localparam logic [WDOG_W-1:0] c_wdogLast = WDOG_W'(TIMEOUT_CYCLES - 1);

    // Client-side signals gathered into arrays indexed by client number
    logic [1:0]        w_cReadReq;
    logic [1:0]        w_cWriteReq;
    logic [ADDR_W-1:0] w_cAddress [2];
    logic [DATA_W-1:0] w_cData    [2];

    logic [1:0]        w_pending;
    logic [ADDR_W-1:0] w_slotAddr [2];
    logic [DATA_W-1:0] w_slotData [2];
    logic [1:0]        w_slotKind;
    logic [1:0]        w_clear;
    logic [1:0]        w_pendNext;

    assign w_cReadReq  = {c1_readReq, c0_readReq};
    assign w_cWriteReq = {c1_writeReq, c0_writeReq};
    assign w_cAddress[0] = c0_ramAddress;
    assign w_cAddress[1] = c1_ramAddress;
    assign w_cData[0]    = c0_ramOut;
    assign w_cData[1]    = c1_ramOut;

    for (genvar n = 0; n < 2; n++) begin : g_slot
        ram_arb_slot #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .readReq    (w_cReadReq[n]),
            .writeReq   (w_cWriteReq[n]),
            .reqAddress (w_cAddress[n]),
            .reqData    (w_cData[n]),
            .clear      (w_clear[n]),
            .pending    (w_pending[n]),
            .address    (w_slotAddr[n]),
            .data       (w_slotData[n]),
            .kind       (w_slotKind[n])
        );

        // Mirror of the slot's own update, used to register busy in step
        // with the pending flags.
        assign w_pendNext[n] = !w_clear[n] &&
                               (w_pending[n] || w_cReadReq[n] || w_cWriteReq[n]);
    end

    arbState_t         r_state, w_stateNext;
    logic              r_owner, w_ownerNext;
    logic              r_lastGrant, w_lastGrantNext;
    logic [WDOG_W-1:0] r_wdog, w_wdogNext;

    logic              w_sel;
    logic              w_ownKind;
    logic              w_match;
    logic              w_forced;
    logic              w_complete;
    logic [ADDR_W-1:0] w_ramAddressNext;
    logic [DATA_W-1:0] w_ramOutNext;
    logic              w_readReqNext;
    logic              w_writeReqNext;
    logic [1:0]        w_readAckNext;
    logic [1:0]        w_writeAckNext;
    logic [DATA_W-1:0] w_retData;

    always_comb begin
        w_stateNext      = r_state;
        w_ownerNext      = r_owner;
        w_lastGrantNext  = r_lastGrant;
        w_wdogNext       = r_wdog;
        w_ramAddressNext = ramAddress;
        w_ramOutNext     = ramOut;
        w_readReqNext    = 1'b0;
        w_writeReqNext   = 1'b0;
        w_clear          = 2'b00;
        w_complete       = 1'b0;
        w_forced         = 1'b0;
        w_match          = 1'b0;
        w_readAckNext    = 2'b00;
        w_writeAckNext   = 2'b00;
        // Tie goes to the client that was not served last
        w_sel            = (&w_pending) ? !r_lastGrant : !w_pending[0];
        w_ownKind        = w_slotKind[r_owner];

        case (r_state)
            ST_IDLE: begin
                if (|w_pending) begin
                    w_ramAddressNext = w_slotAddr[w_sel];
                    w_ramOutNext     = w_slotData[w_sel];
                    w_readReqNext    = (w_slotKind[w_sel] == KIND_READ);
                    w_writeReqNext   = (w_slotKind[w_sel] == KIND_WRITE);
                    w_ownerNext      = w_sel;
                    w_wdogNext       = '0;
                    w_stateNext      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_match  = (w_ownKind == KIND_READ)  ? readAck : writeAck;
                w_forced = c_wdogEn && !w_match && (r_wdog == c_wdogLast);
                if (w_match || w_forced) begin
                    w_complete              = 1'b1;
                    w_clear[r_owner]        = 1'b1;
                    w_readAckNext[r_owner]  = (w_ownKind == KIND_READ);
                    w_writeAckNext[r_owner] = (w_ownKind == KIND_WRITE);
                    w_lastGrantNext         = r_owner;
                    w_stateNext             = ST_IDLE;
                end else if (r_wdog != '1) begin
                    w_wdogNext = r_wdog + 1'b1;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_retData = w_forced ? TIMEOUT_DATA : ramIn;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_wdog      <= '0;
            ramAddress  <= '0;
            ramOut      <= '0;
            readReq     <= 1'b0;
            writeReq    <= 1'b0;
            c0_ramIn    <= '0;
            c1_ramIn    <= '0;
            c0_readAck  <= 1'b0;
            c1_readAck  <= 1'b0;
            c0_writeAck <= 1'b0;
            c1_writeAck <= 1'b0;
            busy        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_owner     <= w_ownerNext;
            r_lastGrant <= w_lastGrantNext;
            r_wdog      <= w_wdogNext;
            ramAddress  <= w_ramAddressNext;
            ramOut      <= w_ramOutNext;
            readReq     <= w_readReqNext;
            writeReq    <= w_writeReqNext;
            if (w_readAckNext[0]) c0_ramIn <= w_retData;
            if (w_readAckNext[1]) c1_ramIn <= w_retData;
            c0_readAck  <= w_readAckNext[0];
            c1_readAck  <= w_readAckNext[1];
            c0_writeAck <= w_writeAckNext[0];
            c1_writeAck <= w_writeAckNext[1];
            busy        <= (|w_pendNext) || (w_stateNext == ST_WAIT);
            timeout     <= w_complete && w_forced;
        end
    end

endmodule : ram_arbiter

`default_nettype wire
